// File: rtl/loader_pkg.sv
// loader_pkg
// Shared definitions for the program_loader byte-stream boot loader:
// FSM state encoding, host command bytes and the frame checksum width.
// No ports; imported with "import loader_pkg::*".
package loader_pkg;

   // FSM state encoding. Kept as plain 4-bit constants so the encoding stays
   // visible in waveforms and matches older tooling that decodes it.
   typedef logic [3:0] loader_state_t;

   localparam loader_state_t S_IDLE    = 4'd0;
   localparam loader_state_t S_ADDR_LO = 4'd1;
   localparam loader_state_t S_ADDR_HI = 4'd2;
   localparam loader_state_t S_CNT_LO  = 4'd3;
   localparam loader_state_t S_CNT_HI  = 4'd4;
   localparam loader_state_t S_DATA    = 4'd5;
   localparam loader_state_t S_CSUM    = 4'd6;
   localparam loader_state_t S_RUN     = 4'd7;
   localparam loader_state_t S_ERROR   = 4'd8;

   // Host command bytes (ASCII 'P', 'D', 'G', 'H').
   localparam logic [7:0] CMD_PM   = 8'h50;
   localparam logic [7:0] CMD_DM   = 8'h44;
   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] CMD_HALT = 8'h48;

   // Frame checksum is a running XOR over whole bytes.
   localparam int CSUM_W = 8;

endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler
// Collects four host bytes, least significant first, into one 32-bit word.
// The first three bytes are held in a shift store; the fourth byte is passed
// straight through so the completed word is available in the same cycle the
// last byte is accepted (word_done high for exactly that cycle).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset; drops any partial word
//   byte_valid in   a byte belonging to a data word is being accepted
//   byte_in    in   that byte
//   word       out  assembled word (valid while word_done is high)
//   word_done  out  the fourth byte of a word is being accepted this cycle
module word_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_done
);

   logic [1:0]  byte_idx;
   logic [23:0] low_bytes;

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx  <= 2'd0;
         low_bytes <= 24'd0;
      end else if (byte_valid) begin
         // Index wraps 3 -> 0 on its own, so the next word starts clean.
         byte_idx <= byte_idx + 2'd1;
         case (byte_idx)
            2'd0:    low_bytes[7:0]   <= byte_in;
            2'd1:    low_bytes[15:8]  <= byte_in;
            2'd2:    low_bytes[23:16] <= byte_in;
            default: ;
         endcase
      end
   end

   assign word_done = byte_valid && (byte_idx == 2'd3);
   assign word      = {byte_in, low_bytes};

endmodule

// File: rtl/program_loader.sv
// program_loader
// Boot loader in front of the single-cycle CPU. Parses framed commands from a
// host byte channel, writes little-endian 32-bit words into program or data
// memory through the CPU top's load ports, and controls the CPU reset.
//
// Frame: cmd, addr_lo, addr_hi, cnt_lo, cnt_hi, cnt x 4 data bytes (LSB
// first). addr/cnt are in words. Commands: 0x50 PM load, 0x44 DM load,
// 0x47 run CPU, 0x48 halt CPU.
//
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing XOR
// checksum byte on every PM/DM frame (XOR of cmd through last data byte).
//
// Ports:
//   clk                    in   clock, rising edge
//   rst                    in   synchronous active-high reset
//   in_valid / in_data     in   host byte channel
//   in_ready               out  always 1 (no back-pressure)
//   pm_write_en            out  one-cycle PM write strobe
//   pm_write_address       out  PM byte address (word index << 2)
//   pm_data_in             out  PM write data
//   dm_write_en            out  one-cycle DM write strobe
//   dm_write_address_load  out  DM word index
//   dm_data_in_load        out  DM write data
//   cpu_rstn               out  active-low CPU reset, high only while running
//   busy                   out  a frame is being received
//   error                  out  sticky error, cleared only by rst
module program_loader
   import loader_pkg::*;
#(
   parameter int BITS     = 32,
   parameter int PM_DEPTH = 256,
   parameter int DM_DEPTH = 256
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic                          pm_write_en,
   output logic [$clog2(PM_DEPTH)+1:0]   pm_write_address,
   output logic [BITS-1:0]               pm_data_in,
   output logic                          dm_write_en,
   output logic [$clog2(DM_DEPTH)-1:0]   dm_write_address_load,
   output logic [BITS-1:0]               dm_data_in_load,
   output logic                          cpu_rstn,
   output logic                          busy,
   output logic                          error
);

   localparam int PM_AW = $clog2(PM_DEPTH);
   localparam int DM_AW = $clog2(DM_DEPTH);

   // Where a PM/DM frame goes once its last data word has been accepted.
`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t S_FRAME_END = S_CSUM;
`else
   localparam loader_state_t S_FRAME_END = S_IDLE;
`endif

   loader_state_t       state;
   logic                target_dm;
   logic [15:0]         addr;
   logic [15:0]         cnt;
   logic [CSUM_W-1:0]   csum;

   logic [31:0]         word;
   logic                word_done;

   logic [15:0]         cnt_full;
   logic [16:0]         end_addr;
   logic [16:0]         depth;
   logic                range_bad;

   assign in_ready = 1'b1;

   word_assembler u_word_assembler (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (in_valid && (state == S_DATA)),
      .byte_in    (in_data),
      .word       (word),
      .word_done  (word_done)
   );

   // Header range check, evaluated while cnt_hi is on the bus. 17-bit sum so
   // addr + cnt can never wrap back into range.
   assign cnt_full  = {in_data, cnt[7:0]};
   assign end_addr  = {1'b0, addr} + {1'b0, cnt_full};
   assign depth     = target_dm ? 17'(DM_DEPTH) : 17'(PM_DEPTH);
   assign range_bad = end_addr > depth;

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= S_IDLE;
         target_dm             <= 1'b0;
         addr                  <= 16'd0;
         cnt                   <= 16'd0;
         csum                  <= '0;
         error                 <= 1'b0;
         pm_write_en           <= 1'b0;
         pm_write_address      <= '0;
         pm_data_in            <= '0;
         dm_write_en           <= 1'b0;
         dm_write_address_load <= '0;
         dm_data_in_load       <= '0;
      end else begin
         // Write stage: register address/data with the strobe, one cycle
         // after the fourth byte of a word.
         pm_write_en <= 1'b0;
         dm_write_en <= 1'b0;
         if (word_done) begin
            if (target_dm) begin
               dm_write_en           <= 1'b1;
               dm_write_address_load <= addr[DM_AW-1:0];
               dm_data_in_load       <= BITS'(word);
            end else begin
               pm_write_en      <= 1'b1;
               pm_write_address <= {addr[PM_AW-1:0], 2'b00};
               pm_data_in       <= BITS'(word);
            end
         end

         // Byte parse stage.
         if (in_valid) begin
            // Running XOR; reseeded with the command byte in IDLE below.
            csum <= csum ^ in_data;
            case (state)
               S_IDLE: begin
                  case (in_data)
                     CMD_PM: begin
                        target_dm <= 1'b0;
                        csum      <= in_data;
                        state     <= S_ADDR_LO;
                     end
                     CMD_DM: begin
                        target_dm <= 1'b1;
                        csum      <= in_data;
                        state     <= S_ADDR_LO;
                     end
                     CMD_GO:   state <= S_RUN;
                     CMD_HALT: state <= S_IDLE;
                     default: begin
                        error <= 1'b1;
                        state <= S_ERROR;
                     end
                  endcase
               end
               S_ADDR_LO: begin
                  addr[7:0] <= in_data;
                  state     <= S_ADDR_HI;
               end
               S_ADDR_HI: begin
                  addr[15:8] <= in_data;
                  state      <= S_CNT_LO;
               end
               S_CNT_LO: begin
                  cnt[7:0] <= in_data;
                  state    <= S_CNT_HI;
               end
               S_CNT_HI: begin
                  cnt <= cnt_full;
                  if (range_bad) begin
                     error <= 1'b1;
                     state <= S_ERROR;
                  end else if (cnt_full == 16'd0) begin
                     state <= S_FRAME_END;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (word_done) begin
                     cnt  <= cnt - 16'd1;
                     addr <= addr + 16'd1;
                     if (cnt == 16'd1) begin
                        state <= S_FRAME_END;
                     end
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               S_CSUM: begin
                  // Compare against the XOR of everything before this byte.
                  if (in_data == csum) begin
                     state <= S_IDLE;
                  end else begin
                     error <= 1'b1;
                     state <= S_ERROR;
                  end
               end
`endif
               S_RUN: begin
                  if (in_data == CMD_HALT) begin
                     state <= S_IDLE;
                  end
               end
               S_ERROR: state <= S_ERROR;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign cpu_rstn = (state == S_RUN);
   assign busy     = (state != S_IDLE) && (state != S_RUN) && (state != S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        pm_write_en;
   logic [9:0]  pm_write_address;
   logic [31:0] pm_data_in;
   logic        dm_write_en;
   logic [7:0]  dm_write_address_load;
   logic [31:0] dm_data_in_load;
   logic        cpu_rstn;
   logic        busy;
   logic        error;

   program_loader #(.BITS(32), .PM_DEPTH(256), .DM_DEPTH(256)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .in_valid              (in_valid),
      .in_data               (in_data),
      .in_ready              (in_ready),
      .pm_write_en           (pm_write_en),
      .pm_write_address      (pm_write_address),
      .pm_data_in            (pm_data_in),
      .dm_write_en           (dm_write_en),
      .dm_write_address_load (dm_write_address_load),
      .dm_data_in_load       (dm_data_in_load),
      .cpu_rstn              (cpu_rstn),
      .busy                  (busy),
      .error                 (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_dm;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst) begin
         if (pm_write_en && dm_write_en) check("both_strobes", 32'd1, 32'd0);
         if (pm_write_en || dm_write_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'd1, 32'd0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_target", {31'd0, dm_write_en}, {31'd0, e.is_dm});
               if (dm_write_en) begin
                  check("dm_addr", {24'd0, dm_write_address_load}, e.addr);
                  check("dm_data", dm_data_in_load, e.data);
               end else begin
                  check("pm_addr", {22'd0, pm_write_address}, e.addr);
                  check("pm_data", pm_data_in, e.data);
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      idle(n);
      rst = 1'b0;
   endtask

   // Sends a complete PM/DM frame (with checksum when enabled) and queues
   // the writes it should produce. gap = idle cycles after every byte.
   task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                             input int cnt, input logic [31:0] w0,
                             input logic [31:0] w1, input int gap);
      logic [7:0]  cs;
      logic [7:0]  hdr[5];
      logic [31:0] w;
      wr_t         e;
      hdr[0] = cmd;
      hdr[1] = addr[7:0];
      hdr[2] = addr[15:8];
      hdr[3] = 8'(cnt);
      hdr[4] = 8'(cnt >> 8);
      for (int i = 0; i < cnt; i++) begin
         e.is_dm = (cmd == 8'h44);
         e.addr  = e.is_dm ? 32'(addr) + 32'(i) : (32'(addr) + 32'(i)) << 2;
         e.data  = (i == 0) ? w0 : w1;
         exp_q.push_back(e);
      end
      cs = 8'h00;
      for (int i = 0; i < 5; i++) begin
         send_byte(hdr[i]);
         cs ^= hdr[i];
         if (gap > 0) idle(gap);
      end
      for (int i = 0; i < cnt; i++) begin
         w = (i == 0) ? w0 : w1;
         for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            cs ^= w[8*k +: 8];
            if (gap > 0) idle(gap);
         end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(cs);
`endif
      idle(2);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      idle(2);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_pm_we", {31'd0, pm_write_en}, 32'd0);
      check("rst_dm_we", {31'd0, dm_write_en}, 32'd0);
      check("rst_pm_addr", {22'd0, pm_write_address}, 32'd0);
      check("rst_pm_data", pm_data_in, 32'd0);
      check("rst_dm_addr", {24'd0, dm_write_address_load}, 32'd0);
      check("rst_dm_data", dm_data_in_load, 32'd0);
      check("rst_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      rst = 1'b0;

      // Reset in the middle of a data word: partial word must be dropped.
      send_byte(8'h50); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB);
      check("mid_busy", {31'd0, busy}, 32'd1);
      do_reset(2);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_error", {31'd0, error}, 32'd0);
      check("midrst_pm_we", {31'd0, pm_write_en}, 32'd0);
      idle(3);

      // PM load, two words at word address 2, full rate.
      send_frame(8'h50, 16'h0002, 2, 32'h12345678, 32'hDEADBEEF, 0);
      check("pm_all_written", 32'(exp_q.size()), 32'd0);
      check("pm_busy_done", {31'd0, busy}, 32'd0);

      // Zero-count frame: header only, no writes, back to idle.
      send_frame(8'h50, 16'h0010, 0, 32'h0, 32'h0, 0);
      check("cnt0_busy", {31'd0, busy}, 32'd0);
      check("cnt0_error", {31'd0, error}, 32'd0);

      // Bursty in_valid: a byte every other cycle.
      send_frame(8'h50, 16'h0020, 2, 32'hA5A5_0F0F, 32'h0123_4567, 1);
      check("burst_all_written", 32'(exp_q.size()), 32'd0);

      // DM load at the very last legal word, then run and halt.
      send_frame(8'h44, 16'h00FF, 1, 32'h0000_0005, 32'h0, 0);
      check("dm_all_written", 32'(exp_q.size()), 32'd0);
      check("pre_go_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
      send_byte(8'h47);
      check("go_cpu_rstn", {31'd0, cpu_rstn}, 32'd1);
      check("run_busy", {31'd0, busy}, 32'd0);
      send_byte(8'h50);
      check("run_discard", {31'd0, cpu_rstn}, 32'd1);
      send_byte(8'h48);
      check("halt_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
      check("halt_busy", {31'd0, busy}, 32'd0);
      // Idle is back: a fresh frame parses normally.
      send_frame(8'h50, 16'h0000, 1, 32'hCAFE_F00D, 32'h0, 0);
      check("post_halt_written", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      // Corrupted checksum: word still written, then error.
      begin
         wr_t e;
         e.is_dm = 1'b1; e.addr = 32'd3; e.data = 32'h1122_3344;
         exp_q.push_back(e);
         send_byte(8'h44); send_byte(8'h03); send_byte(8'h00);
         send_byte(8'h01); send_byte(8'h00);
         send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
         send_byte(8'hFF);
         idle(1);
         check("csum_word_written", 32'(exp_q.size()), 32'd0);
         check("csum_bad_error", {31'd0, error}, 32'd1);
         send_byte(8'h47);
         check("csum_go_blocked", {31'd0, cpu_rstn}, 32'd0);
         do_reset(2);
      end
`endif

      // Range error: addr 0xFF + cnt 2 > 256, detected on cnt_hi.
      send_byte(8'h50); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h02);
      check("range_pre_error", {31'd0, error}, 32'd0);
      send_byte(8'h00);
      check("range_error", {31'd0, error}, 32'd1);
      check("range_busy", {31'd0, busy}, 32'd0);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h47);
      check("range_go_blocked", {31'd0, cpu_rstn}, 32'd0);
      check("range_error_sticky", {31'd0, error}, 32'd1);
      check("range_in_ready", {31'd0, in_ready}, 32'd1);

      // Bad command in idle.
      do_reset(2);
      check("rst_clears_error", {31'd0, error}, 32'd0);
      send_byte(8'h48);
      check("halt_in_idle_ok", {31'd0, error}, 32'd0);
      send_byte(8'h7A);
      check("badcmd_error", {31'd0, error}, 32'd1);
      send_byte(8'h47);
      check("badcmd_go_blocked", {31'd0, cpu_rstn}, 32'd0);

      idle(4);
      check("no_pending_writes", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #200000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
